// File: rtl/spram_access_ctrl_if.sv
// Request/response bundle between a client and the single-port RAM access controller.
interface spram_access_ctrl_if;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 4;

  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_valid;

  modport master (
    output wr_addr, wr_data, wr_mask, wr_valid, rd_addr, rd_valid,
    input  wr_ready, rd_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  wr_addr, wr_data, wr_mask, wr_valid, rd_addr, rd_valid,
    output wr_ready, rd_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/spram_access_ctrl.sv
// Arbitrates one write port and one read port onto a single-port RAM with
// nibble write enables; read data returns three cycles after acceptance.
module spram_access_ctrl #(
  parameter int unsigned WAIT_MAX  = 4,
  parameter int unsigned READ_PRIO = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spram_access_ctrl_if.slave   bus,
  output logic [13:0]          ram_addr,
  output logic [15:0]          ram_din,
  output logic [3:0]           ram_mask,
  output logic                 ram_wren,
  output logic                 ram_cs,
  output logic                 ram_standby,
  output logic                 ram_sleep,
  output logic                 ram_poweroff,
  input  logic [15:0]          ram_dout
);

  localparam int unsigned CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  logic [CW-1:0] wait_cnt;
  logic          last_grant_rd;  // 0 = last conflict went to the write
  logic          conflict;
  logic          wr_wins;
  logic          grant_wr;
  logic          grant_rd;
  logic          rd_issue;
  logic          rd_pend;

  assign ram_standby  = 1'b0;
  assign ram_sleep    = 1'b0;
  assign ram_poweroff = 1'b0;

  // Arbiter: at most one grant per cycle, nothing granted while in reset.
  always_comb begin
    conflict = bus.wr_valid && bus.rd_valid;
    wr_wins  = 1'b0;
    if (READ_PRIO != 0) begin
      wr_wins = (wait_cnt == CW'(WAIT_MAX));
    end else begin
      wr_wins = last_grant_rd;
    end
    grant_wr = rst_n && bus.wr_valid && (!bus.rd_valid || wr_wins);
    grant_rd = rst_n && bus.rd_valid && !grant_wr;
  end

  assign bus.wr_ready = grant_wr;
  assign bus.rd_ready = grant_rd;

  // Starvation counter for a write repeatedly losing to reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.wr_valid || grant_wr) begin
      wait_cnt <= '0;
    end else if (conflict && (wait_cnt != CW'(WAIT_MAX))) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Remembers the winner of the most recent conflict for alternation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_rd <= 1'b0;
    end else if (conflict) begin
      last_grant_rd <= grant_rd;
    end
  end

  // Registers the accepted command onto the RAM pins; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_mask <= '0;
      ram_wren <= 1'b0;
      ram_cs   <= 1'b0;
    end else if (grant_wr) begin
      ram_addr <= bus.wr_addr;
      ram_din  <= bus.wr_data;
      ram_mask <= bus.wr_mask;
      ram_wren <= 1'b1;
      ram_cs   <= 1'b1;
    end else if (grant_rd) begin
      ram_addr <= bus.rd_addr;
      ram_mask <= '0;
      ram_wren <= 1'b0;
      ram_cs   <= 1'b1;
    end else begin
      ram_mask <= '0;
      ram_wren <= 1'b0;
      ram_cs   <= 1'b0;
    end
  end

  // Read tracking: issue -> RAM access -> capture of ram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_issue      <= 1'b0;
      rd_pend       <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
    end else begin
      rd_issue      <= grant_rd;
      rd_pend       <= rd_issue;
      bus.rsp_valid <= rd_pend;
      if (rd_pend) begin
        bus.rsp_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_spram_access_ctrl.sv
// Drives two controllers (read-priority and alternating) with identical stimulus
// against behavioural RAMs and a transaction-level reference model.
module tb_spram_access_ctrl;

  localparam int unsigned WAIT_MAX = 4;
  localparam int unsigned HN = 4096;

  logic clk;
  logic rst_n;

  spram_access_ctrl_if ifa ();
  spram_access_ctrl_if ifb ();

  logic [13:0] ram_addr_x [2];
  logic [15:0] ram_din_x  [2];
  logic [15:0] ram_dout_x [2];
  logic [3:0]  ram_mask_x [2];
  logic        ram_wren_x [2];
  logic        ram_cs_x   [2];
  logic        ram_sb_x   [2];
  logic        ram_sl_x   [2];
  logic        ram_po_x   [2];

  spram_access_ctrl #(.WAIT_MAX(WAIT_MAX), .READ_PRIO(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .ram_addr(ram_addr_x[0]), .ram_din(ram_din_x[0]), .ram_mask(ram_mask_x[0]),
    .ram_wren(ram_wren_x[0]), .ram_cs(ram_cs_x[0]), .ram_standby(ram_sb_x[0]),
    .ram_sleep(ram_sl_x[0]), .ram_poweroff(ram_po_x[0]), .ram_dout(ram_dout_x[0])
  );

  spram_access_ctrl #(.WAIT_MAX(WAIT_MAX), .READ_PRIO(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .ram_addr(ram_addr_x[1]), .ram_din(ram_din_x[1]), .ram_mask(ram_mask_x[1]),
    .ram_wren(ram_wren_x[1]), .ram_cs(ram_cs_x[1]), .ram_standby(ram_sb_x[1]),
    .ram_sleep(ram_sl_x[1]), .ram_poweroff(ram_po_x[1]), .ram_dout(ram_dout_x[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous single-port RAMs with nibble write enables.
  logic [15:0] bmem [2][16384];
  bit          ram_init_done;
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int k = 0; k < 2; k++)
        for (int a = 0; a < 16384; a++) bmem[k][a] <= 16'h0;
      ram_init_done <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ram_cs_x[k]) begin
          if (ram_wren_x[k])
            bmem[k][ram_addr_x[k]] <= (bmem[k][ram_addr_x[k]] & ~nib_bits(ram_mask_x[k])) |
                                      (ram_din_x[k] & nib_bits(ram_mask_x[k]));
          else
            ram_dout_x[k] <= bmem[k][ram_addr_x[k]];
        end
      end
    end
  end

  function automatic logic [15:0] nib_bits(logic [3:0] m);
    return {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
  endfunction

  int checks;
  int errors;

  // stimulus shared by both DUTs
  logic        wv, rv;
  logic [13:0] wa, ra;
  logic [15:0] wd;
  logic [3:0]  wm;

  // reference model state
  logic [15:0] mmem [2][16384];
  int          losses [2];
  bit          last_rd [2];
  logic [13:0] h_addr [2];
  logic [15:0] h_din [2];
  logic [15:0] last_rsp [2];
  bit          e_cs [2];
  bit          e_wren [2];
  logic [3:0]  e_mask [2];
  bit          hist_v [2][HN];
  logic [15:0] hist_d [2][HN];
  int          edge_n;
  int          g [2];
  logic [9:0]  wr_hist [2];
  logic [11:0] rv_hist [2];

  task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
    end
  endtask

  function automatic int hi(int n);
    return (n + int'(HN)) % int'(HN);
  endfunction

  function automatic logic o_wr(int k);   return k != 0 ? ifb.wr_ready  : ifa.wr_ready;  endfunction
  function automatic logic o_rd(int k);   return k != 0 ? ifb.rd_ready  : ifa.rd_ready;  endfunction
  function automatic logic o_rv(int k);   return k != 0 ? ifb.rsp_valid : ifa.rsp_valid; endfunction
  function automatic logic [15:0] o_rdat(int k); return k != 0 ? ifb.rsp_data : ifa.rsp_data; endfunction

  // Grant from the arbitration rules: 0 none, 1 write, 2 read.
  function automatic int exp_grant(int k);
    if (!rst_n) return 0;
    if (!wv && !rv) return 0;
    if (wv && !rv) return 1;
    if (rv && !wv) return 2;
    if (k == 0) return (losses[0] >= int'(WAIT_MAX)) ? 1 : 2;
    return last_rd[1] ? 1 : 2;
  endfunction

  task automatic drive();
    ifa.wr_valid = wv; ifa.wr_addr = wa; ifa.wr_data = wd; ifa.wr_mask = wm;
    ifa.rd_valid = rv; ifa.rd_addr = ra;
    ifb.wr_valid = wv; ifb.wr_addr = wa; ifb.wr_data = wd; ifb.wr_mask = wm;
    ifb.rd_valid = rv; ifb.rd_addr = ra;
  endtask

  // One clock cycle: check readies, apply acceptance to the model, check outputs.
  task automatic cyc();
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      g[k] = exp_grant(k);
      chk("wr_ready", k, 32'(o_wr(k)), 32'(g[k] == 1));
      chk("rd_ready", k, 32'(o_rd(k)), 32'(g[k] == 2));
      wr_hist[k] = {wr_hist[k][8:0], o_wr(k)};
    end
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      hist_v[k][hi(edge_n)] = 1'b0;
      e_cs[k] = 1'b0; e_wren[k] = 1'b0; e_mask[k] = 4'h0;
      if (g[k] == 1) begin
        for (int i = 0; i < 4; i++)
          if (wm[i]) mmem[k][wa][4*i +: 4] = wd[4*i +: 4];
        h_addr[k] = wa; h_din[k] = wd;
        e_cs[k] = 1'b1; e_wren[k] = 1'b1; e_mask[k] = wm;
      end else if (g[k] == 2) begin
        hist_v[k][hi(edge_n)] = 1'b1;
        hist_d[k][hi(edge_n)] = mmem[k][ra];
        h_addr[k] = ra; e_cs[k] = 1'b1;
      end
      if (k == 0) begin
        if (!wv || g[0] == 1) losses[0] = 0;
        else if (rv && losses[0] < int'(WAIT_MAX)) losses[0]++;
      end else if (wv && rv) begin
        last_rd[1] = (g[1] == 2);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("ram_cs", k, 32'(ram_cs_x[k]), 32'(e_cs[k]));
      chk("ram_wren", k, 32'(ram_wren_x[k]), 32'(e_wren[k]));
      chk("ram_mask", k, 32'(ram_mask_x[k]), 32'(e_mask[k]));
      chk("ram_addr", k, 32'(ram_addr_x[k]), 32'(h_addr[k]));
      chk("ram_din", k, 32'(ram_din_x[k]), 32'(h_din[k]));
      if (edge_n >= 2 && hist_v[k][hi(edge_n - 2)]) begin
        last_rsp[k] = hist_d[k][hi(edge_n - 2)];
        chk("rsp_valid", k, 32'(o_rv(k)), 32'(1));
      end else begin
        chk("rsp_valid", k, 32'(o_rv(k)), 32'(0));
      end
      chk("rsp_data", k, 32'(o_rdat(k)), 32'(last_rsp[k]));
      rv_hist[k] = {rv_hist[k][10:0], o_rv(k)};
    end
  endtask

  // Asynchronous reset held for n edges with both requesters asking.
  task automatic do_reset(int n);
    wv = 1'b1; rv = 1'b1;
    drive();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_wr_ready", k, 32'(o_wr(k)), 32'(0));
      chk("rst_rd_ready", k, 32'(o_rd(k)), 32'(0));
      chk("rst_ram_cs", k, 32'(ram_cs_x[k]), 32'(0));
      chk("rst_ram_wren", k, 32'(ram_wren_x[k]), 32'(0));
      chk("rst_ram_mask", k, 32'(ram_mask_x[k]), 32'(0));
      chk("rst_ram_addr", k, 32'(ram_addr_x[k]), 32'(0));
      chk("rst_ram_din", k, 32'(ram_din_x[k]), 32'(0));
      chk("rst_rsp_valid", k, 32'(o_rv(k)), 32'(0));
      chk("rst_rsp_data", k, 32'(o_rdat(k)), 32'(0));
      losses[k] = 0; last_rd[k] = 1'b0; h_addr[k] = '0; h_din[k] = '0;
      last_rsp[k] = '0; e_cs[k] = 1'b0; e_wren[k] = 1'b0; e_mask[k] = '0;
      hist_v[k][hi(edge_n)] = 1'b0;
      hist_v[k][hi(edge_n - 1)] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < 2; k++) hist_v[k][hi(edge_n)] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wv = 1'b0; rv = 1'b0;
    drive();
  endtask

  task automatic idle(int n);
    wv = 1'b0; rv = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic wr(logic [13:0] a, logic [15:0] d, logic [3:0] m);
    wv = 1'b1; rv = 1'b0; wa = a; wd = d; wm = m;
    cyc();
  endtask

  task automatic rd(logic [13:0] a);
    wv = 1'b0; rv = 1'b1; ra = a;
    cyc();
  endtask

  initial begin
    checks = 0; errors = 0; edge_n = 0;
    wv = 1'b0; rv = 1'b0; wa = '0; ra = '0; wd = '0; wm = '0;
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16384; a++) mmem[k][a] = 16'h0;
      for (int e = 0; e < int'(HN); e++) hist_v[k][e] = 1'b0;
      wr_hist[k] = '0; rv_hist[k] = '0;
    end
    do_reset(2);
    for (int k = 0; k < 2; k++) begin
      chk("ram_standby", k, 32'(ram_sb_x[k]), 32'(0));
      chk("ram_sleep", k, 32'(ram_sl_x[k]), 32'(0));
      chk("ram_poweroff", k, 32'(ram_po_x[k]), 32'(0));
    end
    idle(2);

    // write then read the next cycle returns the new data
    wr(14'h0005, 16'h1234, 4'hF);
    rd(14'h0005);
    idle(2);
    chk("req24_valid", 0, 32'(ifa.rsp_valid), 32'(1));
    chk("req24_data", 0, 32'(ifa.rsp_data), 32'(16'h1234));
    idle(1);

    // partial-nibble overwrite
    wr(14'h0010, 16'hFFFF, 4'hF);
    wr(14'h0010, 16'h0000, 4'h3);
    rd(14'h0010);
    idle(3);
    chk("req25_data", 0, 32'(ifa.rsp_data), 32'(16'hFF00));
    chk("req25_data", 1, 32'(ifb.rsp_data), 32'(16'hFF00));

    // zero-mask write is a visible no-op
    wr(14'h0010, 16'h5555, 4'h0);
    rd(14'h0010);
    idle(3);
    chk("mask0_data", 0, 32'(ifa.rsp_data), 32'(16'hFF00));

    // both valid continuously: read-priority with starvation limit vs alternation
    wv = 1'b1; rv = 1'b1; wa = 14'h0020; wd = 16'hA5A5; wm = 4'hF; ra = 14'h0021;
    repeat (10) cyc();
    chk("req26_pattern", 0, 32'(wr_hist[0]), 32'(10'b0000100001));
    chk("req27_pattern", 1, 32'(wr_hist[1]), 32'(10'b0101010101));
    idle(3);

    // back-to-back reads stream contiguous responses
    for (int i = 0; i < 8; i++) wr(14'(i), 16'(i), 4'hF);
    for (int i = 0; i < 8; i++) rd(14'(i));
    idle(4);
    chk("req28_stream", 0, 32'(rv_hist[0]), 32'(12'b001111111100));
    chk("req28_last", 0, 32'(ifa.rsp_data), 32'(16'h0007));

    // reset right after a read is accepted discards it
    rd(14'h0003);
    do_reset(2);
    idle(5);
    chk("req29_no_rsp", 0, 32'(rv_hist[0][4:0]), 32'(0));
    chk("req29_no_rsp", 1, 32'(rv_hist[1][4:0]), 32'(0));

    // randomized traffic over a small address window
    for (int n = 0; n < 400; n++) begin
      wv = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 2) != 0);
      wa = 14'($urandom_range(0, 15));
      ra = 14'($urandom_range(0, 15));
      wd = 16'($urandom);
      wm = 4'($urandom_range(0, 15));
      cyc();
      if (n == 200) do_reset(1);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spram_access_ctrl.md
SPRAM_ACCESS_CTRL -- requirements
Module: spram_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 4: maximum consecutive cycles a pending write may lose arbitration to reads.
REQ-002 SHALL have parameter READ_PRIO, default 1: 1 = reads win conflicts, subject to REQ-011; 0 = strict alternation on conflict.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have write-request ports: wr_addr input 14; wr_data input 16; wr_mask input 4 (nibble write enables); wr_valid input 1; wr_ready output 1.
REQ-006 SHALL have read-request ports: rd_addr input 14; rd_valid input 1; rd_ready output 1.
REQ-007 SHALL have read-response ports: rsp_data output 16; rsp_valid output 1 (no backpressure).
REQ-008 SHALL have memory-side ports: ram_addr output 14; ram_din output 16; ram_mask output 4; ram_wren output 1; ram_cs output 1; ram_standby, ram_sleep, ram_poweroff output 1 (each constant 0); ram_dout input 16.

Function
REQ-009 SHALL accept at most one request per cycle; acceptance is valid AND ready at a rising edge.
REQ-010 SHALL drive wr_ready and rd_ready combinationally from the arbiter: ready high only for the granted requester; both low when neither is valid.
REQ-011 SHALL, on conflict (both valid), grant by READ_PRIO; if READ_PRIO=1 and wait_cnt equals WAIT_MAX, grant the write.
REQ-012 SHALL keep wait_cnt (width clog2(WAIT_MAX+1)): increment, saturating at WAIT_MAX, on each conflict cycle the write loses; clear on write acceptance or when wr_valid is low.
REQ-013 SHALL, for READ_PRIO=0, hold a last_grant flag and give a conflict to the requester not granted in the previous conflict; flag resets to "write" so the first conflict goes to the read.
REQ-014 SHALL register the accepted command into ram_* at the acceptance edge: write -> ram_addr=wr_addr, ram_din=wr_data, ram_mask=wr_mask, ram_wren=1, ram_cs=1; read -> ram_addr=rd_addr, ram_wren=0, ram_mask=0, ram_cs=1.
REQ-015 SHALL, on an edge with no acceptance, drive ram_cs=0, ram_wren=0, ram_mask=0 and hold ram_addr and ram_din.
REQ-016 SHALL track read issue with a 2-stage shift (rd_issue, rd_pend); at acceptance edge E, RAM samples at E+1, rsp_data <= ram_dout at E+2, and rsp_valid is high for exactly the one cycle following E+2.
REQ-017 SHALL sustain one read per cycle; back-to-back reads produce back-to-back rsp_valid pulses in acceptance order.
REQ-018 SHALL preserve program order: a read accepted after a write to the same address returns the written data, including a read accepted the cycle immediately after the write.
REQ-019 SHALL hold rsp_data unchanged while rsp_valid is low.
REQ-020 SHALL treat wr_mask=0 as a legal no-op write: ram_cs=1 and ram_wren=1 for one cycle; memory unchanged.

Reset
REQ-021 SHALL, while rst_n is low, force ram_addr=0, ram_din=0, ram_mask=0, ram_wren=0, ram_cs=0, rsp_data=0, rsp_valid=0, wait_cnt=0, last_grant=write, and clear the read shift stages.
REQ-022 SHALL discard reads in flight when reset asserts mid-operation; no rsp_valid follows deassertion.
REQ-023 SHALL keep wr_ready=0 and rd_ready=0 while rst_n is low.

Verification
REQ-024 Write 0x1234 to 0x0005, mask 0xF, then read 0x0005 the next cycle -> rsp_valid one cycle after edge E+2, rsp_data=0x1234.
REQ-025 Write 0xFFFF to 0x0010, mask 0xF; write 0x0000, mask 0x3; read 0x0010 -> rsp_data=0xFF00.
REQ-026 READ_PRIO=1, WAIT_MAX=4; wr_valid and rd_valid held high -> 4 reads granted, then 1 write; pattern repeats.
REQ-027 READ_PRIO=0; both valid for 6 cycles -> grants R,W,R,W,R,W.
REQ-028 8 consecutive reads of 0x0000..0x0007 preloaded with index values -> 8 contiguous rsp_valid cycles, data 0..7 in order.
REQ-029 Assert rst_n low one cycle after a read is accepted -> all outputs 0 and no rsp_valid pulse after release.
